// File: rtl/div_issue_controller_if.sv
// Request/writeback channel between the execute stage and the divide issue controller.
// The requester drives master, the controller implements slave.
interface div_issue_controller_if #(
  parameter int XLEN = 32,
  parameter int ID_W = 3
);
  logic            issue_valid;
  logic            issue_ready;
  logic [XLEN-1:0] issue_rs1;
  logic [XLEN-1:0] issue_rs2;
  logic [1:0]      issue_op;
  logic [ID_W-1:0] issue_id;
  logic            wb_valid;
  logic            wb_ack;
  logic [ID_W-1:0] wb_id;
  logic [XLEN-1:0] wb_data;

  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_op, issue_id, wb_ack,
    input  issue_ready, wb_valid, wb_id, wb_data
  );

  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_op, issue_id, wb_ack,
    output issue_ready, wb_valid, wb_id, wb_data
  );
endinterface

// File: rtl/div_issue_controller.sv
// Sign-handling sequencer in front of an unsigned divider core with a 2-entry request FIFO.
// Optional DIV_RESULT_REUSE_EN: reuse the last core result for a request with identical operands.
module div_issue_controller #(
  parameter int XLEN = 32,
  parameter int ID_W = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  div_issue_controller_if.slave  bus,
  output logic                   div_start,
  output logic [XLEN-1:0]        div_dividend,
  output logic [XLEN-1:0]        div_divisor,
  input  logic                   div_done,
  input  logic [XLEN-1:0]        div_quotient,
  input  logic [XLEN-1:0]        div_remainder,
  input  logic                   div_divisor_is_zero
);
  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, WAIT = 2'd2, RESULT = 2'd3} state_t;

  function automatic logic [XLEN-1:0] neg_f(input logic [XLEN-1:0] v);
    return ~v + {{(XLEN-1){1'b0}}, 1'b1};
  endfunction

  state_t          state_r, state_next_s;
  logic [XLEN-1:0] fifo_rs1_r [2];
  logic [XLEN-1:0] fifo_rs2_r [2];
  logic [1:0]      fifo_op_r  [2];
  logic [ID_W-1:0] fifo_id_r  [2];
  logic            wr_ptr_r, rd_ptr_r, full_r;
  logic [1:0]      count_r, count_next_s;
  logic            push_s, pop_s, hit_s;
  logic [XLEN-1:0] head_rs1_s, head_rs2_s, reuse_data_s;
  logic [1:0]      head_op_s;
  logic [ID_W-1:0] head_id_s;
  logic            rs1_neg_s, rs2_neg_s;
  logic [XLEN-1:0] rs1_r, q_fix_s, r_fix_s, res_s;
  logic            rem_r, neg_q_r, neg_r_r;
  logic [ID_W-1:0] id_r;
  logic            div_start_r, wb_valid_r;
  logic [ID_W-1:0] wb_id_r;
  logic [XLEN-1:0] wb_data_r, dividend_r, divisor_r;

  assign push_s          = bus.issue_valid & ~full_r;
  assign bus.issue_ready = ~full_r;
  assign bus.wb_valid    = wb_valid_r;
  assign bus.wb_id       = wb_id_r;
  assign bus.wb_data     = wb_data_r;
  assign div_start       = div_start_r;
  assign div_dividend    = dividend_r;
  assign div_divisor     = divisor_r;

  assign head_rs1_s = fifo_rs1_r[rd_ptr_r];
  assign head_rs2_s = fifo_rs2_r[rd_ptr_r];
  assign head_op_s  = fifo_op_r[rd_ptr_r];
  assign head_id_s  = fifo_id_r[rd_ptr_r];
  assign rs1_neg_s  = ~head_op_s[0] & head_rs1_s[XLEN-1];
  assign rs2_neg_s  = ~head_op_s[0] & head_rs2_s[XLEN-1];

  // FIFO payload storage, written on every accepted request
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_rs1_r[wr_ptr_r] <= bus.issue_rs1;
      fifo_rs2_r[wr_ptr_r] <= bus.issue_rs2;
      fifo_op_r[wr_ptr_r]  <= bus.issue_op;
      fifo_id_r[wr_ptr_r]  <= bus.issue_id;
    end
  end

  // FIFO occupancy after this cycle's push/pop
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + 2'd1;
      2'b01:   count_next_s = count_r - 2'd1;
      default: count_next_s = count_r;
    endcase
  end

  // FIFO pointers and registered full flag
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
      full_r   <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= ~wr_ptr_r;
      if (pop_s)  rd_ptr_r <= ~rd_ptr_r;
      count_r <= count_next_s;
      full_r  <= (count_next_s == 2'd2);
    end
  end

`ifdef DIV_RESULT_REUSE_EN
  logic            reuse_valid_r, reuse_uns_r, uns_r;
  logic [XLEN-1:0] reuse_rs1_r, reuse_rs2_r, reuse_q_r, reuse_r_r, rs2_r;

  // Match the FIFO head against the last completed operand pair
  always_comb begin
    hit_s        = reuse_valid_r && (head_rs1_s == reuse_rs1_r) &&
                   (head_rs2_s == reuse_rs2_r) && (head_op_s[0] == reuse_uns_r);
    reuse_data_s = head_op_s[1] ? reuse_r_r : reuse_q_r;
  end

  // Keep the original operands and final signed results of the last core run
  always_ff @(posedge clk) begin
    if (rst) begin
      reuse_valid_r <= 1'b0;
      reuse_uns_r   <= 1'b0;
      uns_r         <= 1'b0;
      rs2_r         <= {XLEN{1'b0}};
      reuse_rs1_r   <= {XLEN{1'b0}};
      reuse_rs2_r   <= {XLEN{1'b0}};
      reuse_q_r     <= {XLEN{1'b0}};
      reuse_r_r     <= {XLEN{1'b0}};
    end else begin
      if (pop_s) begin
        uns_r <= head_op_s[0];
        rs2_r <= head_rs2_s;
      end
      if (state_r == WAIT && div_done) begin
        reuse_valid_r <= 1'b1;
        reuse_uns_r   <= uns_r;
        reuse_rs1_r   <= rs1_r;
        reuse_rs2_r   <= rs2_r;
        reuse_q_r     <= q_fix_s;
        reuse_r_r     <= r_fix_s;
      end
    end
  end
`else
  assign hit_s        = 1'b0;
  assign reuse_data_s = {XLEN{1'b0}};
`endif

  // Next state and FIFO pop
  always_comb begin
    state_next_s = state_r;
    pop_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (count_r != 2'd0) begin
          pop_s        = 1'b1;
          state_next_s = hit_s ? RESULT : START;
        end else begin
          state_next_s = IDLE;
        end
      end
      START: state_next_s = WAIT;
      WAIT: begin
        if (div_done) state_next_s = RESULT;
        else          state_next_s = WAIT;
      end
      RESULT: begin
        if (bus.wb_ack) state_next_s = IDLE;
        else            state_next_s = RESULT;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Sign and divide-by-zero fixup of the core result
  always_comb begin
    if (div_divisor_is_zero) begin
      q_fix_s = {XLEN{1'b1}};
      r_fix_s = rs1_r;
    end else begin
      q_fix_s = neg_q_r ? neg_f(div_quotient)  : div_quotient;
      r_fix_s = neg_r_r ? neg_f(div_remainder) : div_remainder;
    end
    res_s = rem_r ? r_fix_s : q_fix_s;
  end

  // FSM state, registered outputs and popped-request context
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      div_start_r <= 1'b0;
      wb_valid_r  <= 1'b0;
      wb_id_r     <= {ID_W{1'b0}};
      wb_data_r   <= {XLEN{1'b0}};
      dividend_r  <= {XLEN{1'b0}};
      divisor_r   <= {XLEN{1'b0}};
      rs1_r       <= {XLEN{1'b0}};
      id_r        <= {ID_W{1'b0}};
      rem_r       <= 1'b0;
      neg_q_r     <= 1'b0;
      neg_r_r     <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      div_start_r <= (state_next_s == START);
      wb_valid_r  <= (state_next_s == RESULT);
      if (pop_s) begin
        rs1_r      <= head_rs1_s;
        id_r       <= head_id_s;
        rem_r      <= head_op_s[1];
        neg_q_r    <= rs1_neg_s ^ rs2_neg_s;
        neg_r_r    <= rs1_neg_s;
        dividend_r <= rs1_neg_s ? neg_f(head_rs1_s) : head_rs1_s;
        divisor_r  <= rs2_neg_s ? neg_f(head_rs2_s) : head_rs2_s;
      end
      if (state_r == WAIT && div_done) begin
        wb_id_r   <= id_r;
        wb_data_r <= res_s;
      end else if (pop_s && hit_s) begin
        wb_id_r   <= head_id_s;
        wb_data_r <= reuse_data_s;
      end
    end
  end
endmodule
